// File: rtl/pwm_seq_ctrl.sv
// PWM sequence controller: steps a PWM engine through up to four stored
// entries, optionally looping the whole sequence, with stop/drain handling
// and an engine-acknowledge timeout.
module pwm_seq_ctrl #(
    parameter int unsigned N_ENT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_duty,
    input  logic [15:0] cfg_dessert,
    input  logic [7:0]  cfg_pulses,
    input  logic [7:0]  cfg_pat,
    input  logic [1:0]  seq_last,
    input  logic [7:0]  loop_num,
    input  logic        start,
    input  logic        stop,
    input  logic        eng_busy,
    output logic        pwm_en,
    output logic [7:0]  duty_num,
    output logic [15:0] pulse_dessert,
    output logic [7:0]  pulse_num,
    output logic [7:0]  PAT,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  cur_idx
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  loop_cnt_q, loop_cnt_d;
    logic [1:0]  seq_last_q, seq_last_d;
    logic [7:0]  loop_num_q, loop_num_d;
    logic [3:0]  arm_cnt_q, arm_cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  duty_q, duty_d;
    logic [15:0] dessert_q, dessert_d;
    logic [7:0]  pulses_q, pulses_d;
    logic [7:0]  pat_q, pat_d;
    logic [1:0]  cur_idx_q, cur_idx_d;

    // Entry layout: {duty[39:32], dessert[31:16], pulses[15:8], pat[7:0]}
    logic [39:0] ent_q [N_ENT];
    logic [39:0] ent_sel;
    logic [7:0]  loop_nxt;
    logic [3:0]  arm_nxt;

    assign ent_sel  = ent_q[idx_q];
    assign loop_nxt = loop_cnt_q + 8'd1;
    assign arm_nxt  = arm_cnt_q + 4'd1;

    // Entry storage; writable only while no sequence is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_ENT; i++) begin
                ent_q[i] <= '0;
            end
        end else if (cfg_we && (state_q == IDLE)) begin
            ent_q[cfg_addr] <= {cfg_duty, cfg_dessert, cfg_pulses, cfg_pat};
        end
    end

    // Next-state and register updates for the sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        loop_cnt_d = loop_cnt_q;
        seq_last_d = seq_last_q;
        loop_num_d = loop_num_q;
        arm_cnt_d  = arm_cnt_q;
        done_d     = 1'b0;
        err_d      = err_q;
        duty_d     = duty_q;
        dessert_d  = dessert_q;
        pulses_d   = pulses_q;
        pat_d      = pat_q;
        cur_idx_d  = cur_idx_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    idx_d      = '0;
                    loop_cnt_d = '0;
                    seq_last_d = seq_last;
                    loop_num_d = loop_num;
                    err_d      = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                duty_d    = ent_sel[39:32];
                dessert_d = ent_sel[31:16];
                pulses_d  = ent_sel[15:8];
                pat_d     = ent_sel[7:0];
                cur_idx_d = idx_q;
                arm_cnt_d = '0;
                state_d   = stop ? DRAIN : ARM;
            end
            ARM: begin
                arm_cnt_d = arm_nxt;
                if (stop) begin
                    state_d = DRAIN;
                end else if (eng_busy) begin
                    state_d = RUN;
                end else if (arm_nxt == 4'd15) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (!eng_busy) begin
                    if (idx_q < seq_last_q) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = LOAD;
                    end else if ((loop_num_q != 8'd0) && (loop_nxt == loop_num_q)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d      = '0;
                        loop_cnt_d = loop_nxt;
                        state_d    = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (!eng_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            loop_cnt_q <= '0;
            seq_last_q <= '0;
            loop_num_q <= '0;
            arm_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            duty_q     <= '0;
            dessert_q  <= '0;
            pulses_q   <= '0;
            pat_q      <= '0;
            cur_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            loop_cnt_q <= loop_cnt_d;
            seq_last_q <= seq_last_d;
            loop_num_q <= loop_num_d;
            arm_cnt_q  <= arm_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            duty_q     <= duty_d;
            dessert_q  <= dessert_d;
            pulses_q   <= pulses_d;
            pat_q      <= pat_d;
            cur_idx_q  <= cur_idx_d;
        end
    end

    // pwm_en is decoded from the state register so an asynchronous reset
    // removes it immediately; infinite entries keep it asserted through RUN.
    assign pwm_en        = (state_q == ARM) || ((state_q == RUN) && (pulses_q == 8'd0));
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign duty_num      = duty_q;
    assign pulse_dessert = dessert_q;
    assign pulse_num     = pulses_q;
    assign PAT           = pat_q;
    assign cur_idx       = cur_idx_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed bench for pwm_seq_ctrl with a small PWM-engine model.
module tb_pwm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [7:0]  cfg_duty = '0;
    logic [15:0] cfg_dessert = '0;
    logic [7:0]  cfg_pulses = '0;
    logic [7:0]  cfg_pat = '0;
    logic [1:0]  seq_last = '0;
    logic [7:0]  loop_num = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        eng_busy = 1'b0;
    logic        pwm_en;
    logic [7:0]  duty_num;
    logic [15:0] pulse_dessert;
    logic [7:0]  pulse_num;
    logic [7:0]  PAT;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  cur_idx;

    int n_checks = 0;
    int n_fail = 0;

    // Engine model controls/state
    logic        eng_rst = 1'b1;
    logic        eng_dead = 1'b0;
    logic [15:0] rem = '0;
    logic        inf = 1'b0;
    logic [1:0]  drain = '0;
    int          eng_runs = 0;

    pwm_seq_ctrl #(.N_ENT(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_duty(cfg_duty), .cfg_dessert(cfg_dessert), .cfg_pulses(cfg_pulses),
        .cfg_pat(cfg_pat), .seq_last(seq_last), .loop_num(loop_num),
        .start(start), .stop(stop), .eng_busy(eng_busy), .pwm_en(pwm_en),
        .duty_num(duty_num), .pulse_dessert(pulse_dessert), .pulse_num(pulse_num),
        .PAT(PAT), .busy(busy), .done(done), .err(err), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    // Engine: starts on pwm_en, finite entries run 2*pulse_num cycles,
    // infinite entries run until pwm_en drops then take 3 cycles to drain.
    always @(negedge clk) begin
        if (eng_rst || eng_dead) begin
            eng_busy <= 1'b0;
            rem      <= '0;
            inf      <= 1'b0;
            drain    <= '0;
        end else if (!eng_busy) begin
            if (pwm_en) begin
                eng_busy <= 1'b1;
                inf      <= (pulse_num == 8'd0);
                rem      <= {7'd0, pulse_num, 1'b0};
                drain    <= 2'd3;
                eng_runs <= eng_runs + 1;
            end
        end else if (inf) begin
            if (!pwm_en) begin
                drain <= drain - 2'd1;
                if (drain == 2'd1) eng_busy <= 1'b0;
            end
        end else begin
            rem <= rem - 16'd1;
            if (rem == 16'd1) eng_busy <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_ent(input logic [1:0] a, input logic [7:0] d,
                             input logic [15:0] g, input logic [7:0] p,
                             input logic [7:0] pt);
        cfg_we = 1'b1; cfg_addr = a; cfg_duty = d; cfg_dessert = g;
        cfg_pulses = p; cfg_pat = pt;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; eng_rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({pwm_en, busy, done, err, cur_idx, duty_num, pulse_dessert, pulse_num, PAT} !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pwm=%b busy=%b done=%b err=%b idx=%0d duty=%0h des=%0h pul=%0h pat=%0h, expected all 0",
                     pwm_en, busy, done, err, cur_idx, duty_num, pulse_dessert, pulse_num, PAT);
        end
        rst_n = 1'b1; eng_rst = 1'b0;
        tick();
        n_checks++;
        if ({busy, done, pwm_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy/done/pwm=%b expected 000", {busy, done, pwm_en});
        end
    endtask

    task automatic test_basic;
        int pwm_cnt, done_cnt, bad_pwm, busy_bad, post, runs0;
        logic [7:0] idx_seq;
        logic prev_busy;
        write_ent(2'd0, 8'd2, 16'd3, 8'd2, 8'b101);
        write_ent(2'd1, 8'd2, 16'd3, 8'd2, 8'b101);
        seq_last = 2'd1; loop_num = 8'd1;
        runs0 = eng_runs;
        pulse_start();
        n_checks++;
        if ({busy, pwm_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_load: got busy/pwm=%b expected 10", {busy, pwm_en});
        end
        tick();
        n_checks++;
        if ({pwm_en, cur_idx, duty_num, pulse_dessert, pulse_num, PAT} !== {1'b1, 2'd0, 8'd2, 16'd3, 8'd2, 8'b101}) begin
            n_fail++;
            $display("FAIL basic_arm: got pwm=%b idx=%0d duty=%0d des=%0d pul=%0d pat=%0h expected 1 0 2 3 2 5",
                     pwm_en, cur_idx, duty_num, pulse_dessert, pulse_num, PAT);
        end
        pwm_cnt = 1; idx_seq = {6'd0, cur_idx}; done_cnt = 0; bad_pwm = 0;
        busy_bad = 0; post = 0; prev_busy = busy;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (pwm_en) begin
                pwm_cnt++;
                idx_seq = {idx_seq[5:0], cur_idx};
                if (eng_busy) bad_pwm++;
            end
            if (done) begin
                done_cnt++;
                if (busy !== 1'b0 || prev_busy !== 1'b1) busy_bad++;
            end
            prev_busy = busy;
            if (done_cnt > 0 && !busy) post++;
            if (post >= 4) break;
        end
        n_checks++;
        if (pwm_cnt !== 2 || idx_seq !== 8'h01) begin
            n_fail++;
            $display("FAIL basic_idx_order: got arm_cycles=%0d idx_seq=%0h expected 2 and 01", pwm_cnt, idx_seq);
        end
        n_checks++;
        if (bad_pwm !== 0) begin
            n_fail++;
            $display("FAIL basic_pwm_arm_only: got %0d pwm cycles with engine busy expected 0", bad_pwm);
        end
        n_checks++;
        if (done_cnt !== 1 || busy_bad !== 0) begin
            n_fail++;
            $display("FAIL basic_done: got done_cnt=%0d busy_bad=%0d expected 1 and 0", done_cnt, busy_bad);
        end
        n_checks++;
        if (eng_runs - runs0 !== 2) begin
            n_fail++;
            $display("FAIL basic_runs: got %0d engine runs expected 2", eng_runs - runs0);
        end
    endtask

    task automatic test_loop;
        int pwm_cnt, done_cnt, bad, post, runs0;
        write_ent(2'd0, 8'd1, 16'd1, 8'd3, 8'hA5);
        seq_last = 2'd0; loop_num = 8'd3;
        runs0 = eng_runs;
        pulse_start();
        // Changing these mid-sequence must not matter
        loop_num = 8'd1; seq_last = 2'd3;
        pwm_cnt = 0; done_cnt = 0; bad = 0; post = 0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (pwm_en) begin
                pwm_cnt++;
                if (cur_idx !== 2'd0) bad++;
            end
            if (done) done_cnt++;
            if (done_cnt > 0 && !busy) post++;
            if (post >= 4) break;
        end
        n_checks++;
        if (eng_runs - runs0 !== 3 || pwm_cnt !== 3) begin
            n_fail++;
            $display("FAIL loop_runs: got runs=%0d arm_cycles=%0d expected 3 and 3", eng_runs - runs0, pwm_cnt);
        end
        n_checks++;
        if (done_cnt !== 1 || bad !== 0) begin
            n_fail++;
            $display("FAIL loop_done: got done_cnt=%0d bad_idx=%0d expected 1 and 0", done_cnt, bad);
        end
        seq_last = 2'd0; loop_num = 8'd1;
    endtask

    task automatic test_infinite;
        int low, n;
        write_ent(2'd0, 8'd4, 16'd0, 8'd0, 8'hFF);
        seq_last = 2'd0; loop_num = 8'd0;
        pulse_start();
        tick();
        low = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!pwm_en || !busy) low++;
        end
        n_checks++;
        if (low !== 0 || eng_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL inf_hold: got low_cycles=%0d eng_busy=%b expected 0 and 1", low, eng_busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({pwm_en, busy, done} !== 3'b010) begin
            n_fail++;
            $display("FAIL inf_stop_drop: got pwm/busy/done=%b expected 010", {pwm_en, busy, done});
        end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n++;
            if (done) break;
        end
        n_checks++;
        if (n !== 3 || {done, busy, eng_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL inf_drain: got cycles=%0d done/busy/eng=%b expected 3 and 100", n, {done, busy, eng_busy});
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL inf_done_width: got done=%b expected 0", done);
        end
        loop_num = 8'd1;
    endtask

    task automatic test_stop_finite;
        int n, bad, runs0;
        write_ent(2'd0, 8'd1, 16'd1, 8'd5, 8'hC3);
        write_ent(2'd1, 8'd2, 16'd2, 8'd1, 8'h3C);
        seq_last = 2'd1; loop_num = 8'd1;
        runs0 = eng_runs;
        pulse_start();
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (pwm_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stopfin_drain: got pwm=%b busy=%b expected 0 1", pwm_en, busy);
        end
        n = 0; bad = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            n++;
            if (cur_idx !== 2'd0 || PAT !== 8'hC3) bad++;
            if (done) break;
        end
        n_checks++;
        if (n !== 7 || eng_busy !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stopfin_complete: got cycles=%0d eng=%b busy=%b expected 7 0 0", n, eng_busy, busy);
        end
        n_checks++;
        if (bad !== 0 || eng_runs - runs0 !== 1) begin
            n_fail++;
            $display("FAIL stopfin_no_next: got bad=%0d runs=%0d expected 0 and 1", bad, eng_runs - runs0);
        end
        seq_last = 2'd0;
    endtask

    task automatic test_timeout;
        int cnt, dcnt;
        bit seen;
        eng_dead = 1'b1;
        write_ent(2'd0, 8'd1, 16'd1, 8'd2, 8'h01);
        seq_last = 2'd0; loop_num = 8'd1;
        pulse_start();
        cnt = 0; dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (pwm_en) cnt++;
            if (done) dcnt++;
            if (err) break;
        end
        n_checks++;
        if (cnt !== 15 || {err, busy, pwm_en, done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_err: got arm_cycles=%0d err/busy/pwm/done=%b expected 15 and 1000", cnt, {err, busy, pwm_en, done});
        end
        repeat (3) begin
            tick();
            if (done) dcnt++;
        end
        n_checks++;
        if (dcnt !== 0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got done_cnt=%0d err=%b expected 0 and 1", dcnt, err);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL start_stop_idle: got busy=%b err=%b expected 0 1", busy, err);
        end
        eng_dead = 1'b0;
        pulse_start();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%b busy=%b expected 0 1", err, busy);
        end
        wait_done(40, seen);
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_rerun_done: got done_seen=%b expected 1", seen);
        end
    endtask

    task automatic test_cfg_reset;
        bit seen;
        bit found;
        write_ent(2'd0, 8'd3, 16'd7, 8'd4, 8'h11);
        write_ent(2'd1, 8'd5, 16'd5, 8'd0, 8'h77);
        seq_last = 2'd0; loop_num = 8'd1;
        pulse_start();
        tick();
        tick();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_duty = 8'd9; cfg_dessert = 16'd9;
        cfg_pulses = 8'd9; cfg_pat = 8'h99;
        tick();
        cfg_we = 1'b0;
        wait_done(40, seen);
        seq_last = 2'd1;
        pulse_start();
        tick();
        n_checks++;
        if ({duty_num, pulse_dessert, pulse_num, PAT} !== {8'd3, 16'd7, 8'd4, 8'h11}) begin
            n_fail++;
            $display("FAIL cfg_write_in_run: got duty=%0d des=%0d pul=%0d pat=%0h expected 3 7 4 11",
                     duty_num, pulse_dessert, pulse_num, PAT);
        end
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (cur_idx == 2'd1 && pwm_en && eng_busy && busy) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_reach_inf_run: got found=%b expected 1", found);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pwm_en, busy, done, err, cur_idx, duty_num, pulse_dessert, pulse_num, PAT} !== 46'd0) begin
            n_fail++;
            $display("FAIL async_reset: got pwm=%b busy=%b done=%b idx=%0d duty=%0h des=%0h pul=%0h pat=%0h expected all 0",
                     pwm_en, busy, done, cur_idx, duty_num, pulse_dessert, pulse_num, PAT);
        end
        eng_rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_no_done: got done/busy=%b expected 00", {done, busy});
        end
        rst_n = 1'b1; eng_rst = 1'b0;
        seq_last = 2'd0;
        tick();
        pulse_start();
        tick();
        n_checks++;
        if ({pwm_en, duty_num, pulse_dessert, pulse_num, PAT} !== {1'b1, 40'd0}) begin
            n_fail++;
            $display("FAIL entries_reset: got pwm=%b duty=%0h des=%0h pul=%0h pat=%0h expected 1 and zeros",
                     pwm_en, duty_num, pulse_dessert, pulse_num, PAT);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(20, seen);
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL entries_reset_stop: got done_seen=%b expected 1", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_infinite();
        test_stop_finite();
        test_timeout();
        test_cfg_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
